if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch sequencer between the PC/redirect logic and the instruction memory port.
//  Owns the fetch address and issues in-order requests under a credit limit.
//  Buffers returned words with their PC in a small FIFO feeding decode.
//  On a redirect it flushes the FIFO and squashes responses still in flight.
// PARAMETERS
//  PC_W       32  fetch address / PC width
//  INSN_W     32  instruction word width
//  BUF_DEPTH  4   FIFO entries; power of 2, >=2; also the outstanding+buffered credit limit
//  RESET_PC   0   fetch_pc value after reset
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  cpu_en         in   1       run enable; low = stop issuing, drain
//  redirect_valid in   1       single-cycle redirect (trap/mret/branch/predict, pre-prioritised)
//  redirect_pc    in   PC_W    new fetch address
//  imem_req       out  1       request valid
//  imem_addr      out  PC_W    request address, word aligned
//  imem_gnt       in   1       request accepted this cycle (req&gnt = issue)
//  imem_rvalid    in   1       response valid, in issue order, >=1 cycle after issue
//  imem_rdata     in   INSN_W  response data
//  insn_valid     out  1       FIFO head valid to decode
//  insn           out  INSN_W  head instruction
//  insn_pc        out  PC_W    PC of head instruction
//  insn_ready     in   1       decode consumes head (valid&ready = pop)
//  fetch_busy     out  1       outstanding!=0 or FIFO non-empty
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_pc=RESET_PC, FIFO empty, outst=0, kill=0;
//   imem_req=0, insn_valid=0, fetch_busy=0, insn/insn_pc=0.
//  FSM: IDLE --cpu_en--> RUN; RUN --!cpu_en--> DRAIN;
//   DRAIN --cpu_en--> RUN; DRAIN --outst==0--> IDLE. Issue only in RUN.
//  Credit: imem_req = RUN && !redirect_valid && (outst + count) < BUF_DEPTH.
//   imem_addr = fetch_pc; on issue fetch_pc += 4 (wraps mod 2^PC_W).
//  Req/addr stay stable until gnt, except across a redirect: an unaccepted
//   req is dropped, not counted; new addr appears the cycle after redirect.
//  outst: +1 on issue, -1 on rvalid; both same cycle = unchanged.
//  Response: if kill!=0, discard and kill-=1; else push {fetch-time pc, rdata}.
//   PC of each in-flight request held in a BUF_DEPTH-entry tag queue.
//  Redirect (any state except IDLE keeps fetch_pc update in all states):
//   fetch_pc<=redirect_pc; FIFO flushed; kill<=outst after this cycle's rvalid
//   (same-cycle rvalid is also discarded); same-cycle pop ignored.
//   No issue in the redirect cycle; first new req the next cycle if RUN.
//  Redirect in IDLE: only fetch_pc updated.
//  redirect_pc[1:0]!=0: low bits forced to 0 (misalign trapped upstream).
//  Simultaneous push and pop on full FIFO: legal (credit prevents overflow).
//  Pop on empty: ignored. Push never exceeds BUF_DEPTH by credit rule.
//  Output latency: rvalid at cycle N -> insn_valid at N+1 (no bypass).
//  cpu_en low mid-fetch: in-flight responses still accepted into FIFO.
// CONFIGURATION
//  IF_FETCH_CTRL_BYPASS_EN defined: when FIFO empty, kill==0 and imem_rvalid,
//   insn/insn_pc/insn_valid driven combinationally from the response (0 cycles);
//   if insn_ready same cycle, word not written to FIFO.
//  Undefined: all responses go through FIFO, 1-cycle latency as above.
// TESTING
//  Reset, cpu_en=1, gnt=1, 1-cycle mem -> addrs 0x0,0x4,0x8...; insn_pc matches, no gaps.
//  insn_ready=0, gnt=1 -> exactly 4 issues (BUF_DEPTH=4), req stays 0 until a pop.
//  2 outstanding (0x10,0x14), redirect to 0x200 -> both responses dropped,
//   next insn_pc=0x200, then 0x204.
//  redirect same cycle as rvalid and pop -> word discarded, FIFO empty next cycle.
//  cpu_en 1->0 with 3 outstanding -> state DRAIN, 3 words buffered, IDLE, fetch_busy stays 1 until popped.
//  fetch_pc=0xFFFFFFFC issue -> next addr 0x0; BYPASS_EN: rvalid on empty FIFO -> insn_valid same cycle.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - credit-limited in-order instruction fetch sequencer with PC-tagged FIFO
// Optional zero-latency response bypass when IF_FETCH_CTRL_BYPASS_EN is defined.
module if_fetch_ctrl #(
  parameter int              PC_W      = 32,
  parameter int              INSN_W    = 32,
  parameter int              BUF_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  input  logic              insn_ready,
  output logic              fetch_busy
);

  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   fetch_pc;
  logic [AW:0]       outst, kill, count;
  logic [AW-1:0]     tag_wr, tag_rd, buf_wr, buf_rd;
  logic [PC_W-1:0]   tag_mem  [BUF_DEPTH];
  logic [PC_W-1:0]   buf_pc   [BUF_DEPTH];
  logic [INSN_W-1:0] buf_insn [BUF_DEPTH];
  logic [AW+1:0]     credit_sum;
  logic              issue, flush, resp_ok, push, pop, head_valid;
  logic              bypass_hit, bypass_take;

  always_comb begin
    state_nxt  = state;
    credit_sum = {1'b0, outst} + {1'b0, count};
    imem_req   = 1'b0;
    case (state)
      IDLE:    if (cpu_en) state_nxt = RUN;
      RUN: begin
        if (!cpu_en) state_nxt = DRAIN;
        imem_req = !redirect_valid && (credit_sum < (AW+2)'(BUF_DEPTH));
      end
      DRAIN: begin
        if (cpu_en)          state_nxt = RUN;
        else if (outst == 0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_addr  = fetch_pc;
  assign issue      = imem_req && imem_gnt;
  // A redirect outside IDLE flushes the FIFO and squashes everything still in flight.
  assign flush      = redirect_valid && (state != IDLE);
  assign resp_ok    = imem_rvalid && !flush && (kill == 0);
  assign head_valid = (count != 0);

`ifdef IF_FETCH_CTRL_BYPASS_EN
  assign bypass_hit  = resp_ok && !head_valid;
  assign bypass_take = bypass_hit && insn_ready;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push       = resp_ok && !bypass_take;
  assign pop        = head_valid && insn_ready && !flush;
  assign insn_valid = head_valid || bypass_hit;
  assign fetch_busy = (outst != 0) || head_valid;

  always_comb begin
    insn    = '0;
    insn_pc = '0;
    if (head_valid) begin
      insn    = buf_insn[buf_rd];
      insn_pc = buf_pc[buf_rd];
    end else if (bypass_hit) begin
      insn    = imem_rdata;
      insn_pc = tag_mem[tag_rd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      outst    <= '0;
      kill     <= '0;
      count    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      state <= state_nxt;

      if (redirect_valid)
        fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
      else if (issue)
        fetch_pc <= fetch_pc + PC_W'(4);

      case ({issue, imem_rvalid})
        2'b10:   outst <= outst + (AW+1)'(1);
        2'b01:   outst <= outst - (AW+1)'(1);
        default: outst <= outst;
      endcase

      // The tag queue tracks every request in flight, killed or not, so it never flushes.
      if (issue)       tag_wr <= tag_wr + AW'(1);
      if (imem_rvalid) tag_rd <= tag_rd + AW'(1);

      if (flush)
        kill <= imem_rvalid ? outst - (AW+1)'(1) : outst;
      else if (imem_rvalid && (kill != 0))
        kill <= kill - (AW+1)'(1);

      if (flush) begin
        buf_wr <= '0;
        buf_rd <= '0;
        count  <= '0;
      end else begin
        if (push) buf_wr <= buf_wr + AW'(1);
        if (pop)  buf_rd <= buf_rd + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      buf_insn[buf_wr] <= imem_rdata;
      buf_pc[buf_wr]   <= tag_mem[tag_rd];
    end
  end

endmodule
